inst_mem_loader: RTL

//   Write-side boot loader for the instruction memory.
//   - Accepts a byte stream on a valid/ready handshake and assembles big-endian 32-bit words.
//   - Issues one word write per assembled word into the instruction memory write port.
//   - Holds the CPU in reset while a program image is being loaded.
//   - Stream format: 4-byte big-endian word count N, then N words of 4 bytes each, MSB first.

---
 rtl/inst_mem_loader_if.sv | 20 ++
 rtl/inst_mem_loader.sv | 105 ++++++++++
 2 files changed

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = loader side, slave = stream source / memory side.
interface inst_mem_loader_if;
   logic [7:0]  inByte;
   logic        inValid;
   logic        inReady;
   logic        wrEnable;
   logic [31:0] wrAddress;
   logic [31:0] wrData;

   modport master (
      input  inByte, inValid,
      output inReady, wrEnable, wrAddress, wrData
   );

   modport slave (
      output inByte, inValid,
      input  inReady, wrEnable, wrAddress, wrData
   );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot loader: big-endian length + word stream -> instruction memory writes, CPU held meanwhile.
// Write issues 1 cycle after a word's 4th byte; inReady depends only on state, so 1 byte/cycle sustains.
module inst_mem_loader #(
   parameter int unsigned MEM_WORDS = 65536,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   inst_mem_loader_if.master        bus,
   output logic                     cpuHold,
   output logic                     done,
   output logic                     error,
   output logic [31:0]              wordCount
);
   typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} state_t;

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

   state_t      state;
   logic [1:0]  byteIdx;
   logic [31:0] lenReg;
   logic [31:0] wordReg;
   logic [31:0] nextLen;
   logic [31:0] nextWord;
   logic        xfer;

   assign bus.inReady = (state == LEN) || (state == DATA);
   assign xfer        = bus.inValid && bus.inReady;
   assign nextLen     = {lenReg[23:0], bus.inByte};
   assign nextWord    = {wordReg[23:0], bus.inByte};

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         byteIdx       <= 2'd0;
         lenReg        <= 32'd0;
         wordReg       <= 32'd0;
         bus.wrEnable  <= 1'b0;
         bus.wrAddress <= BASE_ADDR;
         bus.wrData    <= 32'd0;
         cpuHold       <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         wordCount     <= 32'd0;
      end else begin
         bus.wrEnable <= 1'b0;
         done         <= 1'b0;
         case (state)
            IDLE, ERR: begin
               if (start) begin
                  state     <= LEN;
                  cpuHold   <= 1'b1;
                  wordCount <= 32'd0;
                  error     <= 1'b0;
                  byteIdx   <= 2'd0;
                  lenReg    <= 32'd0;
                  wordReg   <= 32'd0;
               end
            end
            LEN: begin
               if (xfer) begin
                  lenReg  <= nextLen;
                  byteIdx <= byteIdx + 2'd1;
                  if (byteIdx == 2'd3) begin
                     if (nextLen == 32'd0) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        cpuHold <= 1'b0;
                     end else if (nextLen > MEM_LIMIT) begin
                        state <= ERR;
                        error <= 1'b1;
                     end else begin
                        state <= DATA;
                     end
                  end
               end
            end
            DATA: begin
               // wordCount is already N during the last write cycle, so finish on the following edge
               if (wordCount == lenReg) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  cpuHold <= 1'b0;
               end else if (xfer) begin
                  wordReg <= nextWord;
                  byteIdx <= byteIdx + 2'd1;
                  if (byteIdx == 2'd3) begin
                     bus.wrEnable  <= 1'b1;
                     bus.wrData    <= nextWord;
                     bus.wrAddress <= BASE_ADDR + {wordCount[29:0], 2'b00};
                     wordCount     <= wordCount + 32'd1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
